// File: rtl/ping_pong_pkg.sv
// Shared defaults for the ping-pong buffer reader: word geometry, tile depth,
// run length and the reader FSM state encoding.
package ping_pong_pkg;

    localparam int WIDTH          = 8;
    localparam int CHUNK_SIZE     = 2;
    localparam int NUM_CORES_A    = 2;
    localparam int NUM_CORES_B    = 1;
    localparam int MODULE_WIDTH_W = WIDTH * CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B;
    localparam int TOTAL_DEPTH_W  = 8;
    localparam int ADDR_WIDTH_W   = $clog2(TOTAL_DEPTH_W);
    localparam int MAX_FLAG_PP    = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        DRAIN   = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } rd_state_e;

endpackage

// File: rtl/pp_skid_fifo.sv
// Two-entry output FIFO between the bank read port and the downstream
// valid/ready interface; the head entry is held until it is popped.
module pp_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] data,
    output logic [1:0]   count
);

    logic [W-1:0] mem_r [2];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   count_r;

    // Storage, pointers and occupancy; pop is only ever asserted when valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign valid = (count_r != 2'd0);
    assign data  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/pp_buffer_reader.sv
// Reads complete tiles alternately from two ping-pong banks, streams the words
// through a credit-limited two-entry FIFO, and hands each bank back when done.
module pp_buffer_reader
    import ping_pong_pkg::*;
#(
    parameter int MODULE_WIDTH = MODULE_WIDTH_W,
    parameter int TOTAL_DEPTH  = TOTAL_DEPTH_W,
    parameter int ADDR_WIDTH   = $clog2(TOTAL_DEPTH),
    parameter int MAX_FLAG     = MAX_FLAG_PP
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [1:0]                    bank_full_i,
    output logic [1:0]                    bank_release_o,
    output logic                          rd_en_o,
    output logic                          rd_bank_o,
    output logic [ADDR_WIDTH-1:0]         rd_addr_o,
    input  logic [MODULE_WIDTH-1:0]       rd_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [MODULE_WIDTH-1:0]       out_data_o,
    output logic                          out_last_o,
    output logic [$clog2(MAX_FLAG+1)-1:0] tile_cnt_o,
    output logic                          done_o
);

    localparam int CNT_W = $clog2(MAX_FLAG + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_DEPTH - 1);
    localparam logic [CNT_W-1:0]      MAX_CNT   = CNT_W'(MAX_FLAG);

    rd_state_e             state_r;
    logic                  cur_bank_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  inflight_r;
    logic                  inflight_last_r;
    logic [1:0]            release_r;
    logic [CNT_W-1:0]      tile_cnt_r;
    logic                  done_r;

    logic                  issue_s;
    logic                  pop_s;
    logic [1:0]            committed_s;
    logic                  fifo_valid_s;
    logic [1:0]            fifo_count_s;
    logic [MODULE_WIDTH:0] fifo_word_s;
    logic                  fifo_last_s;

    assign fifo_last_s = fifo_word_s[MODULE_WIDTH];
    assign pop_s       = fifo_valid_s & out_ready_i;

    // Credit: the word leaving this cycle frees its slot, so a full-rate
    // stream keeps one word in the FIFO and one read in flight.
    always_comb begin
        committed_s = fifo_count_s + {1'b0, inflight_r} - {1'b0, pop_s};
        if (state_r == READ) begin
            issue_s = (committed_s < 2'd2);
        end else begin
            issue_s = 1'b0;
        end
    end

    // Reader FSM with read-return tracking, release pulse and run counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            cur_bank_r      <= 1'b0;
            addr_r          <= '0;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            release_r       <= 2'b00;
            tile_cnt_r      <= '0;
            done_r          <= 1'b0;
        end else begin
            inflight_r      <= issue_s;
            inflight_last_r <= issue_s && (addr_r == LAST_ADDR);
            release_r       <= 2'b00;
            case (state_r)
                IDLE: begin
                    if (bank_full_i[cur_bank_r]) begin
                        state_r <= READ;
                        addr_r  <= '0;
                    end
                end
                READ: begin
                    if (issue_s) begin
                        if (addr_r == LAST_ADDR) begin
                            addr_r  <= '0;
                            state_r <= DRAIN;
                        end else begin
                            addr_r <= addr_r + ADDR_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    // The tagged word is the final one of the tile, so its
                    // departure leaves nothing buffered or in flight.
                    if (pop_s && fifo_last_s) begin
                        state_r   <= RELEASE;
                        release_r <= cur_bank_r ? 2'b10 : 2'b01;
                    end
                end
                RELEASE: begin
                    cur_bank_r <= ~cur_bank_r;
                    tile_cnt_r <= tile_cnt_r + CNT_W'(1);
                    if ((tile_cnt_r + CNT_W'(1)) == MAX_CNT) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DONE: begin
                    if (start_i) begin
                        tile_cnt_r <= '0;
                        done_r     <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    pp_skid_fifo #(
        .W (MODULE_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_r),
        .push_data ({inflight_last_r, rd_data_i}),
        .pop       (pop_s),
        .valid     (fifo_valid_s),
        .data      (fifo_word_s),
        .count     (fifo_count_s)
    );

    assign rd_en_o        = issue_s;
    assign rd_bank_o      = cur_bank_r;
    assign rd_addr_o      = addr_r;
    assign bank_release_o = release_r;
    assign out_valid_o    = fifo_valid_s;
    assign out_data_o     = fifo_word_s[MODULE_WIDTH-1:0];
    assign out_last_o     = fifo_last_s;
    assign tile_cnt_o     = tile_cnt_r;
    assign done_o         = done_r;

endmodule
